vdec_hs_ser: RTL

VDEC_HS_SER -- requirements
Module: vdec_hs_ser

---
 rtl/vdec_hs_pkg.sv | 48 ++++
 rtl/vdec_hs_cenc.sv | 23 ++
 rtl/vdec_hs_ser.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vdec_hs_pkg.sv
// Shared constants and types for the HS-SCCH symbol-error re-encoder.
// Mode codes, frame lengths, generators and FSM encoding.
package vdec_hs_pkg;

  typedef enum logic [1:0] {
    MODE_P1   = 2'b00,
    MODE_P2   = 2'b01,
    MODE_AGCH = 2'b10,
    MODE_RSV  = 2'b11
  } hs_mode_e;

  localparam int K = 9;
  localparam int TAIL = K - 1;

  localparam logic [K-1:0] G0 = 9'o557;
  localparam logic [K-1:0] G1 = 9'o663;
  localparam logic [K-1:0] G2 = 9'o711;

  localparam logic [5:0] L_P1   = 6'd8;
  localparam logic [5:0] L_P2   = 6'd29;
  localparam logic [5:0] L_AGCH = 6'd22;

  localparam logic [5:0] N_P1   = L_P1 + 6'(TAIL);
  localparam logic [5:0] N_P2   = L_P2 + 6'(TAIL);
  localparam logic [5:0] N_AGCH = L_AGCH + 6'(TAIL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  function automatic logic [5:0] info_len(
    input logic [1:0] m
  );
    logic [5:0] l;
    l = 6'd0;
    unique case (m)
      MODE_P1:   l = L_P1;
      MODE_P2:   l = L_P2;
      MODE_AGCH: l = L_AGCH;
      default:   l = 6'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/vdec_hs_cenc.sv
// K=9 rate-1/3 convolutional encoder step (pure combinational).
// Newest bit sits in the MSB of the tap window.
module vdec_hs_cenc
  import vdec_hs_pkg::*;
(
  input  logic [7:0] state,
  input  logic       bit_in,
  output logic [2:0] code,
  output logic [7:0] next_state
);

  logic [K-1:0] win;

  // tap window: current bit followed by the eight previous bits
  always_comb begin
    win        = {bit_in, state};
    code[0]    = ^(win & G0);
    code[1]    = ^(win & G1);
    code[2]    = ^(win & G2);
    next_state = win[K-1:1];
  end

endmodule

// File: rtl/vdec_hs_ser.sv
// Symbol-error-rate counter: re-encodes decoded HS bits and
// compares against hard decisions of the received soft symbols.
module vdec_hs_ser
  import vdec_hs_pkg::*;
#(
  parameter int SW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ser_start,
  input  logic [1:0]    hs_mode,
  output logic          ser_done,
  output logic          busy,
  output logic          dec_rd_en,
  output logic [5:0]    dec_rd_addr,
  input  logic          dec_rd_data,
  output logic          sym_rd_en,
  output logic [5:0]    sym_rd_addr,
  input  logic [3*SW-1:0] sym_rd_data,
  output logic [7:0]    ser_cnt
);

  state_e     state_q;
  state_e     state_n;
  logic       start_ok;
  logic [5:0] len_q;
  logic [5:0] n_q;
  logic       last_rd;
  logic [5:0] nxt_addr;

  logic       rd_v_q;
  logic       rd_tail_q;
  logic       acc_v_q;
  logic [1:0] err_q;
  logic [7:0] enc_q;

  logic       enc_bit;
  logic [2:0] code;
  logic [7:0] enc_n;
  logic [1:0] err_c;
  logic [8:0] sum;

  assign start_ok = (state_q == S_IDLE) && ser_start;
  assign last_rd  = (sym_rd_addr == 6'(n_q - 6'd1));
  assign nxt_addr = 6'(sym_rd_addr + 6'd1);
  assign enc_bit  = rd_tail_q ? 1'b0 : dec_rd_data;
  assign busy     = (state_q != S_IDLE);
  assign ser_done = (state_q == S_DONE);

  vdec_hs_cenc u_cenc (
    .state      (enc_q),
    .bit_in     (enc_bit),
    .code       (code),
    .next_state (enc_n)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ser_start) begin
          if (hs_mode == MODE_RSV) state_n = S_DONE;
          else                     state_n = S_RUN;
        end
      end
      S_RUN:   if (last_rd) state_n = S_FLUSH;
      S_FLUSH: if (acc_v_q && !rd_v_q) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // read address generation; info bits only for steps below L
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= 6'd0;
      n_q         <= 6'd0;
      dec_rd_en   <= 1'b0;
      dec_rd_addr <= 6'd0;
      sym_rd_en   <= 1'b0;
      sym_rd_addr <= 6'd0;
    end else if (start_ok) begin
      len_q <= info_len(hs_mode);
      n_q   <= info_len(hs_mode) + 6'(TAIL);
      if (hs_mode != MODE_RSV) begin
        dec_rd_en   <= 1'b1;
        dec_rd_addr <= 6'd0;
        sym_rd_en   <= 1'b1;
        sym_rd_addr <= 6'd0;
      end
    end else if (state_q == S_RUN) begin
      if (last_rd) begin
        dec_rd_en <= 1'b0;
        sym_rd_en <= 1'b0;
      end else begin
        sym_rd_addr <= nxt_addr;
        if (nxt_addr < len_q) begin
          dec_rd_en   <= 1'b1;
          dec_rd_addr <= nxt_addr;
        end else begin
          dec_rd_en <= 1'b0;
        end
      end
    end
  end

  // per-step symbol error count against the re-encoded bits
  always_comb begin
    err_c = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (sym_rd_data[i*SW +: SW] != '0 &&
          sym_rd_data[i*SW + SW - 1] != code[i])
        err_c = err_c + 2'd1;
    end
    sum = {1'b0, ser_cnt} + 9'(err_q);
  end

  // read-data pipeline, encoder register and saturating accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v_q    <= 1'b0;
      rd_tail_q <= 1'b0;
      acc_v_q   <= 1'b0;
      err_q     <= 2'd0;
      enc_q     <= 8'd0;
      ser_cnt   <= 8'd0;
    end else begin
      rd_v_q    <= sym_rd_en;
      rd_tail_q <= !dec_rd_en;
      acc_v_q   <= rd_v_q;
      if (rd_v_q) begin
        enc_q <= enc_n;
        err_q <= err_c;
      end
      if (start_ok) begin
        enc_q   <= 8'd0;
        ser_cnt <= 8'd0;
      end else if (acc_v_q) begin
        ser_cnt <= sum[8] ? 8'hFF : sum[7:0];
      end
    end
  end

endmodule
